// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory fetch bus: request/address out, ack/data back.
interface pc_fetch_ctrl_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Program-counter sequencer: boot load, fetch over req/ack, issue to decode,
// then advance by 4 or redirect. Owns the PC register's ldp/cta/load value.
module pc_fetch_ctrl #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_i,
    input  logic              step_i,
    input  logic              boot_ld_i,
    input  logic [ADDR_W-1:0] boot_addr_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_addr_i,
    input  logic              stall_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              ldp_c_o,
    output logic              cta_c_o,
    output logic [ADDR_W-1:0] pc_load_val_c_o,
    pc_fetch_ctrl_if.master   imem,
    output logic              instr_valid_o,
    output logic [DATA_W-1:0] instr_o,
    output logic [ADDR_W-1:0] instr_pc_o,
    output logic [31:0]       issued_cnt_o,
    output logic              fault_o
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_HALT  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              instr_valid_q, instr_valid_d;
    logic [31:0]       issued_cnt_q, issued_cnt_d;
    logic              fault_q, fault_d;
    logic [CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic              step_pend_q, step_pend_d;

    logic go_c;
    logic aligned_c;
    logic accept_c;
    logic tmo_hit_c;

    // Shared decision terms for the FSM and datapath.
    always_comb begin
        go_c      = run_i | step_i | step_pend_q;
        aligned_c = (pc_i[1:0] == 2'b00);
        accept_c  = (state_q == S_ISSUE) & (redirect_i | ~stall_i);
        tmo_hit_c = (tmo_cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a misaligned PC faults before any request goes out.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!boot_ld_i && go_c) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (!aligned_c) begin
                    state_d = S_HALT;
                end else if (imem.imem_ack) begin
                    state_d = S_ISSUE;
                end else if (tmo_hit_c) begin
                    state_d = S_HALT;
                end
            end
            S_ISSUE: begin
                if (accept_c) begin
                    state_d = run_i ? S_FETCH : S_IDLE;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Combinational PC-register controls and fetch request; all forced low in reset.
    always_comb begin
        ldp_c_o         = 1'b0;
        cta_c_o         = 1'b0;
        pc_load_val_c_o = '0;
        imem.imem_req   = 1'b0;
        imem.imem_addr  = pc_i;
        if (!rst) begin
            case (state_q)
                S_IDLE: begin
                    if (boot_ld_i) begin
                        ldp_c_o         = 1'b1;
                        pc_load_val_c_o = boot_addr_i;
                    end
                end
                S_FETCH: begin
                    imem.imem_req = aligned_c;
                end
                S_ISSUE: begin
                    if (redirect_i) begin
                        ldp_c_o         = 1'b1;
                        pc_load_val_c_o = redirect_addr_i;
                    end else if (!stall_i) begin
                        cta_c_o = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Datapath next values: capture, issue count, timeout, fault, pending step.
    always_comb begin
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        issued_cnt_d  = issued_cnt_q;
        fault_d       = fault_q;
        tmo_cnt_d     = '0;
        step_pend_d   = step_pend_q;
        instr_valid_d = (state_d == S_ISSUE);

        if (state_q == S_FETCH && aligned_c) begin
            if (imem.imem_ack) begin
                instr_d    = imem.imem_rdata;
                instr_pc_d = pc_i;
            end else begin
                tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
            end
        end

        if (accept_c) begin
            issued_cnt_d = issued_cnt_q + 32'd1;
        end

        if (state_d == S_HALT) begin
            fault_d = 1'b1;
        end

        // A step seen while busy is remembered; entering FETCH consumes it.
        if (step_i && state_q != S_IDLE) begin
            step_pend_d = 1'b1;
        end else if (state_q != S_FETCH && state_d == S_FETCH) begin
            step_pend_d = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            issued_cnt_q  <= '0;
            fault_q       <= 1'b0;
            tmo_cnt_q     <= '0;
            step_pend_q   <= 1'b0;
        end else begin
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            issued_cnt_q  <= issued_cnt_d;
            fault_q       <= fault_d;
            tmo_cnt_q     <= tmo_cnt_d;
            step_pend_q   <= step_pend_d;
        end
    end

    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign instr_valid_o = instr_valid_q;
    assign issued_cnt_o  = issued_cnt_q;
    assign fault_o       = fault_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          run, step, boot_ld, redirect, stall;
    logic [AW-1:0] boot_addr, redirect_addr, pc;
    logic          ldp, cta;
    logic [AW-1:0] plv;
    logic          instr_valid;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic [31:0]   issued_cnt;
    logic          fault;

    int            n_chk  = 0;
    int            n_fail = 0;
    logic [31:0]   exp_pc;
    logic [31:0]   exp_cnt;

    pc_fetch_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) imem_bus ();

    pc_fetch_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk             (clk),
        .rst             (rst),
        .run_i           (run),
        .step_i          (step),
        .boot_ld_i       (boot_ld),
        .boot_addr_i     (boot_addr),
        .redirect_i      (redirect),
        .redirect_addr_i (redirect_addr),
        .stall_i         (stall),
        .pc_i            (pc),
        .ldp_c_o         (ldp),
        .cta_c_o         (cta),
        .pc_load_val_c_o (plv),
        .imem            (imem_bus),
        .instr_valid_o   (instr_valid),
        .instr_o         (instr),
        .instr_pc_o      (instr_pc),
        .issued_cnt_o    (issued_cnt),
        .fault_o         (fault)
    );

    always #5 clk = ~clk;

    // The PC register this block sequences; shares the reset.
    always @(posedge clk) begin
        if (rst)      pc <= '0;
        else if (ldp) pc <= plv;
        else if (cta) pc <= pc + 32'd4;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hAAAA0000 + ((a - 32'h100) >> 2) + 32'd1;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One instruction from FETCH entry to accept: 'lat' idle request cycles,
    // 'holds' stalled issue cycles, then accept (advance or redirect).
    task automatic do_instr(input int lat, input int holds, input bit redir,
                            input logic [31:0] raddr, input logic stall_acc,
                            input bit step_in_fetch);
        logic [31:0] word;
        word = mem_word(exp_pc);
        for (int c = 0; c <= lat; c++) begin
            imem_bus.imem_ack   = (c == lat);
            imem_bus.imem_rdata = (c == lat) ? word : $urandom;
            step                = step_in_fetch && (c == 0);
            #1;
            chk1 ("fetch_req",   imem_bus.imem_req, 1'b1);
            chk32("fetch_addr",  imem_bus.imem_addr, exp_pc);
            chk1 ("fetch_valid", instr_valid, 1'b0);
            chk1 ("fetch_ldp",   ldp, 1'b0);
            chk1 ("fetch_cta",   cta, 1'b0);
            tick();
        end
        imem_bus.imem_ack = 1'b0;
        step              = 1'b0;
        for (int h = 0; h <= holds; h++) begin
            redirect_addr = raddr;
            redirect      = (h == holds) && redir;
            stall         = (h < holds) ? 1'b1 : (redir ? stall_acc : 1'b0);
            #1;
            chk1 ("issue_valid", instr_valid, 1'b1);
            chk32("issue_instr", instr, word);
            chk32("issue_pc",    instr_pc, exp_pc);
            chk1 ("issue_req",   imem_bus.imem_req, 1'b0);
            if (h < holds) begin
                chk1("hold_ldp", ldp, 1'b0);
                chk1("hold_cta", cta, 1'b0);
            end else if (redir) begin
                chk1 ("redir_ldp", ldp, 1'b1);
                chk1 ("redir_cta", cta, 1'b0);
                chk32("redir_val", plv, raddr);
            end else begin
                chk1 ("adv_ldp", ldp, 1'b0);
                chk1 ("adv_cta", cta, 1'b1);
                chk32("adv_val", plv, 32'h0);
            end
            tick();
        end
        redirect = 1'b0;
        stall    = 1'b0;
        exp_pc   = redir ? raddr : exp_pc + 32'd4;
        exp_cnt  = exp_cnt + 32'd1;
        chk32("pc_after",   pc, exp_pc);
        chk32("issued_cnt", issued_cnt, exp_cnt);
        chk1 ("valid_drop", instr_valid, 1'b0);
    endtask

    initial begin
        logic [31:0] r;
        rst = 1'b1; run = 1'b0; step = 1'b0; boot_ld = 1'b0; redirect = 1'b0; stall = 1'b0;
        boot_addr = '0; redirect_addr = '0;
        imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = '0;
        exp_pc = '0; exp_cnt = '0;

        // Reset values.
        tick();
        chk1("rst_req", imem_bus.imem_req, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        chk1 ("rst_valid",  instr_valid, 1'b0);
        chk32("rst_instr",  instr, 32'h0);
        chk32("rst_ipc",    instr_pc, 32'h0);
        chk32("rst_issued", issued_cnt, 32'h0);
        chk1 ("rst_fault",  fault, 1'b0);
        chk1 ("rst_ldp",    ldp, 1'b0);
        chk1 ("rst_cta",    cta, 1'b0);

        // Boot load.
        boot_ld = 1'b1; boot_addr = 32'h100;
        #1;
        chk1 ("boot_ldp", ldp, 1'b1);
        chk32("boot_val", plv, 32'h100);
        chk1 ("boot_req", imem_bus.imem_req, 1'b0);
        tick();
        boot_ld = 1'b0;
        #1;
        chk1 ("boot_ldp_off", ldp, 1'b0);
        chk32("boot_pc",      pc, 32'h100);
        chk1 ("boot_idle_req", imem_bus.imem_req, 1'b0);
        exp_pc = 32'h100;

        // Free-run, single-cycle memory, back-to-back issues.
        run = 1'b1;
        tick();
        do_instr(0, 0, 1'b0, 32'h0, 1'b0, 1'b0);
        do_instr(0, 0, 1'b0, 32'h0, 1'b0, 1'b0);

        // run drops mid-FETCH; stall then redirect overriding stall.
        run = 1'b0;
        do_instr(1, 1, 1'b1, 32'h200, 1'b1, 1'b0);
        chk1("idle_req0", imem_bus.imem_req, 1'b0);
        tick();
        chk1("idle_req1", imem_bus.imem_req, 1'b0);
        chk32("idle_pc", pc, 32'h200);

        // Single step, with a second step arriving during FETCH.
        step = 1'b1;
        #1;
        chk1("step_idle_req", imem_bus.imem_req, 1'b0);
        tick();
        step = 1'b0;
        do_instr(2, 0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk1("pend_idle_req", imem_bus.imem_req, 1'b0);
        tick();
        do_instr(0, 0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        chk1("step_done_req0", imem_bus.imem_req, 1'b0);
        tick();
        chk1("step_done_req1", imem_bus.imem_req, 1'b0);

        // Randomized free-run traffic.
        run = 1'b1;
        tick();
        for (int i = 0; i < 40; i++) begin
            if (i == 39) run = 1'b0;
            r = $urandom;
            do_instr($urandom_range(0, 3), $urandom_range(0, 2),
                     ($urandom_range(0, 2) == 0), {r[31:2], 2'b00},
                     1'($urandom_range(0, 1)), 1'b0);
        end
        tick();
        chk1("rand_idle_req", imem_bus.imem_req, 1'b0);

        // Ack on the last allowed cycle succeeds; then a real timeout.
        run = 1'b1;
        tick();
        do_instr(int'(TO) - 1, 0, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int c = 0; c < int'(TO); c++) begin
            #1;
            chk1("tmo_req",   imem_bus.imem_req, 1'b1);
            chk1("tmo_fault", fault, 1'b0);
            tick();
        end
        chk1("halt_fault", fault, 1'b1);
        chk1("halt_req",   imem_bus.imem_req, 1'b0);
        chk1("halt_valid", instr_valid, 1'b0);

        // HALT ignores run/step/boot_ld/ack.
        step = 1'b1; boot_ld = 1'b1; boot_addr = 32'h40; imem_bus.imem_ack = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk1("halt_ldp",  ldp, 1'b0);
            chk1("halt_cta",  cta, 1'b0);
            chk1("halt_req2", imem_bus.imem_req, 1'b0);
            chk1("halt_sticky", fault, 1'b1);
            tick();
        end
        chk32("halt_pc", pc, exp_pc);
        step = 1'b0; boot_ld = 1'b0; imem_bus.imem_ack = 1'b0;

        // Reset clears the fault.
        rst = 1'b1;
        #1;
        chk1("rst2_req", imem_bus.imem_req, 1'b0);
        tick();
        rst = 1'b0; run = 1'b0;
        #1;
        chk1 ("rst2_fault",  fault, 1'b0);
        chk32("rst2_issued", issued_cnt, 32'h0);
        chk1 ("rst2_valid",  instr_valid, 1'b0);
        chk32("rst2_instr",  instr, 32'h0);

        // Misaligned boot address faults without ever requesting.
        boot_ld = 1'b1; boot_addr = 32'h102;
        #1;
        chk1 ("mis_ldp", ldp, 1'b1);
        chk32("mis_val", plv, 32'h102);
        tick();
        boot_ld = 1'b0; run = 1'b1;
        #1;
        chk32("mis_pc",   pc, 32'h102);
        chk1 ("mis_req0", imem_bus.imem_req, 1'b0);
        tick();
        chk1("mis_req1",   imem_bus.imem_req, 1'b0);
        chk1("mis_fault0", fault, 1'b0);
        tick();
        chk1("mis_fault1", fault, 1'b1);
        chk1("mis_req2",   imem_bus.imem_req, 1'b0);

        // Reset while a fetch is outstanding; a late ack is ignored.
        rst = 1'b1;
        tick();
        rst = 1'b0; run = 1'b0; boot_ld = 1'b1; boot_addr = 32'h300;
        tick();
        boot_ld = 1'b0; run = 1'b1;
        tick();
        chk1 ("mid_req",  imem_bus.imem_req, 1'b1);
        chk32("mid_addr", imem_bus.imem_addr, 32'h300);
        rst = 1'b1;
        #1;
        chk1("mid_rst_req", imem_bus.imem_req, 1'b0);
        tick();
        rst = 1'b0; run = 1'b0;
        imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'hDEADBEEF;
        #1;
        chk1 ("late_req",    imem_bus.imem_req, 1'b0);
        chk1 ("late_valid",  instr_valid, 1'b0);
        chk32("late_instr",  instr, 32'h0);
        chk32("late_ipc",    instr_pc, 32'h0);
        chk32("late_issued", issued_cnt, 32'h0);
        chk1 ("late_fault",  fault, 1'b0);
        chk32("late_pc",     pc, 32'h0);
        tick();
        imem_bus.imem_ack = 1'b0;
        #1;
        chk32("late_instr2", instr, 32'h0);
        chk1 ("late_valid2", instr_valid, 1'b0);
        chk1 ("late_req2",   imem_bus.imem_req, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
